// File: rtl/bomb_scheduler.sv
// Bomb slot allocator with per-slot fuse/blast timers and a serialised explosion-event stream.
// Placement ack/nack one cycle after the request edge; exp_valid holds the event stable until exp_ready.
module bomb_scheduler #(
    parameter int          NUM_SLOTS    = 6,
    parameter int unsigned FUSE_CYCLES  = 400000000,
    parameter int unsigned BLAST_CYCLES = 50000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   C,
    input  logic [9:0]             b_x,
    input  logic [9:0]             b_y,
    output logic                   place_ack,
    output logic                   place_nack,
    output logic [NUM_SLOTS-1:0]   slot_armed,
    output logic [NUM_SLOTS-1:0]   slot_blast,
    output logic [10*NUM_SLOTS-1:0] slot_x,
    output logic [10*NUM_SLOTS-1:0] slot_y,
    output logic [3:0]             active_count,
    output logic                   full,
    output logic                   exp_valid,
    input  logic                   exp_ready,
    output logic [2:0]             exp_slot,
    output logic [9:0]             exp_x,
    output logic [9:0]             exp_y
);

    typedef enum logic [1:0] {S_FREE, S_ARMED, S_PENDING, S_BLAST} slot_state_t;
    typedef enum logic {OUT_IDLE, OUT_PRESENT} out_state_t;

    slot_state_t r_state     [NUM_SLOTS];
    slot_state_t w_state_nxt [NUM_SLOTS];
    logic [31:0] r_timer     [NUM_SLOTS];
    logic [31:0] w_timer_nxt [NUM_SLOTS];
    logic [9:0]  r_x         [NUM_SLOTS];
    logic [9:0]  r_y         [NUM_SLOTS];
    logic [9:0]  w_x_nxt     [NUM_SLOTS];
    logic [9:0]  w_y_nxt     [NUM_SLOTS];

    out_state_t r_out, w_out_nxt;
    logic [2:0] r_sel, w_sel_nxt;
    logic       r_c_q, r_ack, r_nack;
    logic       w_req, w_accept, w_hs;
    logic       w_any_free, w_dup, w_any_pend;
    logic [2:0] w_free_idx, w_pend_idx;

    assign w_req      = C & ~r_c_q;
    assign w_accept   = w_req & w_any_free & ~w_dup;
    assign w_hs       = (r_out == OUT_PRESENT) & exp_ready;
    assign place_ack  = r_ack;
    assign place_nack = r_nack;
    assign exp_valid  = (r_out == OUT_PRESENT);
    assign exp_slot   = r_sel;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_any_free = 1'b0;
        w_dup      = 1'b0;
        w_any_pend = 1'b0;
        w_free_idx = 3'd0;
        w_pend_idx = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_state[i] == S_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = 3'(i);
            end else if (r_x[i] == b_x && r_y[i] == b_y) begin
                w_dup = 1'b1;
            end
            if (r_state[i] == S_PENDING) begin
                w_any_pend = 1'b1;
                w_pend_idx = 3'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            w_x_nxt[i]     = r_x[i];
            w_y_nxt[i]     = r_y[i];
            case (r_state[i])
                S_FREE: begin
                    if (w_accept && w_free_idx == 3'(i)) begin
                        w_state_nxt[i] = S_ARMED;
                        w_timer_nxt[i] = FUSE_CYCLES - 32'd1;
                        w_x_nxt[i]     = b_x;
                        w_y_nxt[i]     = b_y;
                    end
                end
                S_ARMED: begin
                    if (r_timer[i] == 32'd0) w_state_nxt[i] = S_PENDING;
                    else                     w_timer_nxt[i] = r_timer[i] - 32'd1;
                end
                S_PENDING: begin
                    if (w_hs && r_sel == 3'(i)) begin
                        w_state_nxt[i] = S_BLAST;
                        w_timer_nxt[i] = BLAST_CYCLES - 32'd1;
                    end
                end
                default: begin
                    if (r_timer[i] == 32'd0) w_state_nxt[i] = S_FREE;
                    else                     w_timer_nxt[i] = r_timer[i] - 32'd1;
                end
            endcase
        end
    end

    always_comb begin
        w_out_nxt = r_out;
        w_sel_nxt = r_sel;
        case (r_out)
            OUT_IDLE: begin
                if (w_any_pend) begin
                    w_out_nxt = OUT_PRESENT;
                    w_sel_nxt = w_pend_idx;
                end
            end
            default: begin
                if (exp_ready) w_out_nxt = OUT_IDLE;
            end
        endcase
    end

    always_comb begin
        slot_armed   = '0;
        slot_blast   = '0;
        slot_x       = '0;
        slot_y       = '0;
        active_count = 4'd0;
        exp_x        = 10'd0;
        exp_y        = 10'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_armed[i]      = (r_state[i] == S_ARMED) || (r_state[i] == S_PENDING);
            slot_blast[i]      = (r_state[i] == S_BLAST);
            slot_x[10*i +: 10] = r_x[i];
            slot_y[10*i +: 10] = r_y[i];
            if (r_state[i] != S_FREE) active_count = active_count + 4'd1;
            if (r_sel == 3'(i)) begin
                exp_x = r_x[i];
                exp_y = r_y[i];
            end
        end
        full = ~w_any_free;
    end

    // c_q resets high so a button held through reset never places a bomb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c_q  <= 1'b1;
            r_ack  <= 1'b0;
            r_nack <= 1'b0;
            r_out  <= OUT_IDLE;
            r_sel  <= 3'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= S_FREE;
                r_timer[i] <= 32'd0;
                r_x[i]     <= 10'd0;
                r_y[i]     <= 10'd0;
            end
        end else begin
            r_c_q  <= C;
            r_ack  <= w_accept;
            r_nack <= w_req & ~w_accept;
            r_out  <= w_out_nxt;
            r_sel  <= w_sel_nxt;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
                r_x[i]     <= w_x_nxt[i];
                r_y[i]     <= w_y_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Scoreboard bench for bomb_scheduler with FUSE_CYCLES=10, BLAST_CYCLES=4, six slots.
module tb_bomb_scheduler;

    localparam int NS = 6;

    logic           clk, reset, C, exp_ready;
    logic [9:0]     b_x, b_y;
    logic           place_ack, place_nack, full, exp_valid;
    logic [NS-1:0]  slot_armed, slot_blast;
    logic [10*NS-1:0] slot_x, slot_y;
    logic [3:0]     active_count;
    logic [2:0]     exp_slot;
    logic [9:0]     exp_x, exp_y;

    typedef struct packed {
        logic [2:0] slot;
        logic [9:0] x;
        logic [9:0] y;
    } ev_t;

    ev_t ev_q[$];
    bit  plc_q[$];
    ev_t m_ev;
    bit  m_ack;
    int  n_checks = 0;
    int  n_errors = 0;

    bomb_scheduler #(.NUM_SLOTS(NS), .FUSE_CYCLES(10), .BLAST_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .C(C), .b_x(b_x), .b_y(b_y),
        .place_ack(place_ack), .place_nack(place_nack),
        .slot_armed(slot_armed), .slot_blast(slot_blast),
        .slot_x(slot_x), .slot_y(slot_y),
        .active_count(active_count), .full(full),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_slot(exp_slot), .exp_x(exp_x), .exp_y(exp_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_ctl"}, 64'({place_ack, place_nack, slot_armed, slot_blast, active_count,
                                full, exp_valid, exp_slot}), 64'd0);
        chk({tag, "_slot_x"}, 64'(slot_x), 64'd0);
        chk({tag, "_slot_y"}, 64'(slot_y), 64'd0);
        chk({tag, "_exp_xy"}, 64'({exp_x, exp_y}), 64'd0);
    endtask

    task automatic press(input logic [9:0] x, input logic [9:0] y, input bit ack);
        plc_q.push_back(ack);
        @(posedge clk); #1;
        C = 1'b1; b_x = x; b_y = y;
        @(posedge clk); #1;
        C = 1'b0;
    endtask

    task automatic push_ev(input logic [2:0] s, input logic [9:0] x, input logic [9:0] y);
        ev_t e;
        e.slot = s; e.x = x; e.y = y;
        ev_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((active_count != 4'd0 || ev_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_active"}, 64'(active_count), 64'd0);
        chk({name, "_evq"}, 64'(ev_q.size()), 64'd0);
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (!reset) begin
            if (place_ack || place_nack) begin
                if (plc_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL place_unexpected: got ack=%0b nack=%0b expected none", place_ack, place_nack);
                end else begin
                    m_ack = plc_q.pop_front();
                    chk("place_resp", 64'({place_ack, place_nack}), m_ack ? 64'd2 : 64'd1);
                end
            end
            if (exp_valid && exp_ready) begin
                if (ev_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL event_unexpected: got slot=%0d x=%0d y=%0d expected none", exp_slot, exp_x, exp_y);
                end else begin
                    m_ev = ev_q.pop_front();
                    chk("event", 64'({exp_slot, exp_x, exp_y}), 64'(m_ev));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        reset = 1'b1; C = 1'b0; exp_ready = 1'b0; b_x = '0; b_y = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_check("in_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        rst_check("after_reset");

        // Single bomb: fuse, present, handshake, blast, free.
        press(10'd32, 10'd48, 1'b1);
        chk("t1_armed", 64'(slot_armed), 64'h01);
        chk("t1_count", 64'(active_count), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("t1_pending_no_valid", 64'({exp_valid, slot_armed[0]}), 64'b01);
        @(posedge clk); #1;
        chk("t1_present", 64'({exp_valid, exp_slot, exp_x, exp_y}), 64'({1'b1, 3'd0, 10'd32, 10'd48}));
        push_ev(3'd0, 10'd32, 10'd48);
        exp_ready = 1'b1;
        @(posedge clk); #1;
        exp_ready = 1'b0;
        chk("t1_blast", 64'({exp_valid, slot_armed, slot_blast, active_count}), 64'({1'b0, 6'h00, 6'h01, 4'd1}));
        repeat (3) @(posedge clk);
        #1;
        chk("t1_blast_end", 64'(slot_blast), 64'h01);
        @(posedge clk); #1;
        chk("t1_free", 64'({slot_blast, active_count}), 64'd0);

        // Fill all six slots, seventh rejected; hold exp_ready low.
        for (int i = 0; i < NS; i++) press(10'(100 + i), 10'(200 + i), 1'b1);
        press(10'd300, 10'd300, 1'b0);
        chk("t2_full", 64'({full, active_count, slot_armed}), 64'({1'b1, 4'd6, 6'h3F}));
        chk("t2_slot_x5", 64'(slot_x[59:50]), 64'd105);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("t2_stall_stable", 64'({exp_valid, exp_slot, exp_x, exp_y, slot_armed[0]}),
                64'({1'b1, 3'd0, 10'd100, 10'd200, 1'b1}));
        end
        for (int i = 0; i < NS; i++) push_ev(3'(i), 10'(100 + i), 10'(200 + i));
        exp_ready = 1'b1;
        wait_idle("t2_drain");

        // Duplicate tile rejection, then reuse after the slot frees.
        push_ev(3'd0, 10'd16, 10'd16);
        press(10'd16, 10'd16, 1'b1);
        press(10'd16, 10'd16, 1'b0);
        chk("t3_dup_count", 64'(active_count), 64'd1);
        wait_idle("t3_first");
        push_ev(3'd0, 10'd16, 10'd16);
        press(10'd16, 10'd16, 1'b1);
        wait_idle("t3_second");

        // Several slots pending together: lowest index first, one idle cycle between events.
        exp_ready = 1'b0;
        for (int i = 0; i < 4; i++) press(10'(40 + i), 10'd8, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk("t4_all_pending", 64'({slot_armed, exp_valid, exp_slot}), 64'({6'h0F, 1'b1, 3'd0}));
        for (int i = 0; i < 4; i++) push_ev(3'(i), 10'(40 + i), 10'd8);
        exp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pat[7-i] = exp_valid;
        end
        chk("t4_valid_gaps", 64'(pat), 64'b0101_0100);
        wait_idle("t4_drain");

        // Async reset mid-operation, then button held across reset release.
        exp_ready = 1'b0;
        for (int i = 0; i < 3; i++) press(10'(500 + i), 10'd7, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        chk("t5_pre_reset", 64'({exp_valid, active_count}), 64'({1'b1, 4'd3}));
        @(posedge clk); #3;
        reset = 1'b1;
        C = 1'b1;
        #1;
        rst_check("t5_async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_held_no_place", 64'({active_count, slot_armed}), 64'd0);
        C = 1'b0;
        exp_ready = 1'b1;
        push_ev(3'd0, 10'd5, 10'd5);
        press(10'd5, 10'd5, 1'b1);
        wait_idle("t5_after");

        repeat (3) @(posedge clk);
        #1;
        chk("place_queue_empty", 64'(plc_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
